// File: rtl/axi_burst_write_master_if.sv
// -----------------------------------------------------------------------------
// axi_burst_write_master_if
// Bundles the three sides of the burst write master into one interface:
//   - CPU/LSU request channel   : req_valid/req_ready/req_id/req_addr/req_len/req_size
//   - CPU write-data channel    : wd_valid/wd_ready/wd_data
//   - Completion report         : rsp_valid/rsp_resp
//   - AXI4 AW, W and B channels : aw*, w*, b*
// Modport "master" is the view of axi_burst_write_master itself. Modport "slave"
// is the view of everything around it (CPU side plus interconnect).
// -----------------------------------------------------------------------------
interface axi_burst_write_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
);
    localparam int NB = DATA_W / 8;

    // request
    logic              req_valid;
    logic              req_ready;
    logic [ID_W-1:0]   req_id;
    logic [ADDR_W-1:0] req_addr;
    logic [7:0]        req_len;
    logic [2:0]        req_size;
    // CPU beat data
    logic              wd_valid;
    logic              wd_ready;
    logic [DATA_W-1:0] wd_data;
    // completion
    logic              rsp_valid;
    logic [1:0]        rsp_resp;
    // AXI AW
    logic              awvalid;
    logic              awready;
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    // AXI W
    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic [NB-1:0]     wstrb;
    logic              wlast;
    // AXI B
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic [ID_W-1:0]   bid;

    modport master (
        input  req_valid, req_id, req_addr, req_len, req_size,
        output req_ready,
        input  wd_valid, wd_data,
        output wd_ready,
        output rsp_valid, rsp_resp,
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready
    );

    modport slave (
        output req_valid, req_id, req_addr, req_len, req_size,
        input  req_ready,
        output wd_valid, wd_data,
        input  wd_ready,
        input  rsp_valid, rsp_resp,
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready
    );
endinterface

// File: rtl/axi_burst_write_master.sv
// -----------------------------------------------------------------------------
// axi_burst_write_master
// AXI4 INCR write master with one burst outstanding. A request (id/addr/len/size)
// is accepted in IDLE; AW is then issued from registers while W beats stream in
// from the CPU handshake through a one-entry output register that computes the
// per-beat byte strobes. The burst ends with a one-cycle rsp_valid carrying BRESP.
// Requests whose size exceeds the bus width are answered locally with 2'b10.
//
// Ports:
//   clk      : clock
//   reset_n  : synchronous, active-low reset
//   bus      : axi_burst_write_master_if.master (request, CPU data, response,
//              AXI AW/W/B channels)
// -----------------------------------------------------------------------------
module axi_burst_write_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    axi_burst_write_master_if.master bus
);
    localparam int NB     = DATA_W / 8;
    localparam int LOG2NB = $clog2(NB);
    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_RESP, S_REJ} state_t;

    state_t            r_state;
    state_t            w_next;

    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [2:0]        r_size;
    logic [ADDR_W-1:0] r_beat_addr;
    logic [8:0]        r_beats;      // CPU beats accepted so far (0..len+1)
    logic              r_awvalid;
    logic              r_aw_done;
    logic              r_w_done;
    logic              r_wvalid;
    logic [DATA_W-1:0] r_wdata;
    logic [NB-1:0]     r_wstrb;
    logic              r_wlast;

    logic              w_req_ready;
    logic              w_bready;
    logic              w_rsp_valid;
    logic [1:0]        w_rsp_resp;
    logic              w_wd_ready;
    logic              w_req_hs;
    logic              w_reject;
    logic              w_wd_hs;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_last_hs;
    logic              w_b_hs;

    // Byte lanes written by a beat at address a: from the address offset within
    // the bus word up to the end of the 2^size container holding it. Only an
    // unaligned start address makes this differ from the full container.
    function automatic logic [NB-1:0] beat_strobe(input logic [ADDR_W-1:0] a,
                                                  input logic [2:0]        size);
        logic [NB-1:0] strb;
        int            lo;
        int            hi;
        int            sz;
        sz = 1 << size;
        lo = int'(a[LOG2NB-1:0]);
        hi = (lo & ~(sz - 1)) + sz - 1;
        for (int i = 0; i < NB; i++) begin
            strb[i] = (i >= lo) && (i <= hi);
        end
        return strb;
    endfunction

    // INCR beat address: align down to the transfer size, then step one size.
    function automatic logic [ADDR_W-1:0] next_beat_addr(input logic [ADDR_W-1:0] a,
                                                         input logic [2:0]        size);
        logic [ADDR_W-1:0] sz;
        sz = A_ONE << size;
        return (a & ~(sz - A_ONE)) + sz;
    endfunction

    assign w_req_hs  = bus.req_valid && w_req_ready;
    assign w_reject  = bus.req_size > 3'(LOG2NB);
    assign w_wd_ready = (r_state == S_XFER) && (r_beats <= {1'b0, r_len}) &&
                        (!r_wvalid || bus.wready);
    assign w_wd_hs   = bus.wd_valid && w_wd_ready;
    assign w_aw_hs   = r_awvalid && bus.awready;
    assign w_w_hs    = r_wvalid && bus.wready;
    assign w_last_hs = w_w_hs && r_wlast;
    assign w_b_hs    = bus.bvalid && w_bready;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; AW and the last W beat may finish in either order or together
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_req_hs) w_next = w_reject ? S_REJ : S_XFER;
            S_XFER: if ((r_aw_done || w_aw_hs) && (r_w_done || w_last_hs)) w_next = S_RESP;
            S_RESP: if (w_b_hs) w_next = S_IDLE;
            S_REJ:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        w_req_ready = 1'b0;
        w_bready    = 1'b0;
        w_rsp_valid = 1'b0;
        w_rsp_resp  = 2'b00;
        case (r_state)
            S_IDLE: w_req_ready = 1'b1;
            S_RESP: begin
                w_bready = 1'b1;
                if (bus.bvalid) begin
                    w_rsp_valid = 1'b1;
                    w_rsp_resp  = bus.bresp;
                end
            end
            S_REJ: begin
                w_rsp_valid = 1'b1;
                w_rsp_resp  = 2'b10;
            end
            default: ;
        endcase
    end

    // Request latch, AW channel and W output register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_id        <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_size      <= '0;
            r_beat_addr <= '0;
            r_beats     <= '0;
            r_awvalid   <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_wvalid    <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_wlast     <= 1'b0;
        end else if (w_req_hs) begin
            r_id        <= bus.req_id;
            r_addr      <= bus.req_addr;
            r_len       <= bus.req_len;
            r_size      <= bus.req_size;
            r_beat_addr <= bus.req_addr;
            r_beats     <= '0;
            r_awvalid   <= !w_reject;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_awvalid <= 1'b0;
                r_aw_done <= 1'b1;
            end
            if (w_last_hs) begin
                r_w_done <= 1'b1;
            end
            // A new beat may load in the same cycle the held one retires
            if (w_wd_hs) begin
                r_wvalid    <= 1'b1;
                r_wdata     <= bus.wd_data;
                r_wstrb     <= beat_strobe(r_beat_addr, r_size);
                r_wlast     <= (r_beats[7:0] == r_len);
                r_beats     <= r_beats + 9'd1;
                r_beat_addr <= next_beat_addr(r_beat_addr, r_size);
            end else if (w_w_hs) begin
                r_wvalid <= 1'b0;
                r_wlast  <= 1'b0;
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.wd_ready  = w_wd_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_resp  = w_rsp_resp;
    assign bus.awvalid   = r_awvalid;
    assign bus.awid      = r_id;
    assign bus.awaddr    = r_addr;
    assign bus.awlen     = r_len;
    assign bus.awsize    = r_size;
    assign bus.awburst   = 2'b01;
    assign bus.wvalid    = r_wvalid;
    assign bus.wdata     = r_wdata;
    assign bus.wstrb     = r_wstrb;
    assign bus.wlast     = r_wlast;
    assign bus.bready    = w_bready;
endmodule

// File: tb/tb_axi_burst_write_master.sv
`timescale 1ns/1ps
module tb_axi_burst_write_master;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    axi_burst_write_master_if #(.ADDR_W(32), .DATA_W(64), .ID_W(4)) bus64 ();
    axi_burst_write_master_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) bus32 ();

    axi_burst_write_master #(.ADDR_W(32), .DATA_W(64), .ID_W(4)) dut64 (
        .clk(clk), .reset_n(reset_n), .bus(bus64)
    );
    axi_burst_write_master #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut32 (
        .clk(clk), .reset_n(reset_n), .bus(bus32)
    );

    typedef struct packed {
        logic [31:0]     addr;
        logic [7:0]      len;
        logic [2:0]      size;
        logic [3:0]      id;
        logic [7:0]      aw_delay;
        logic            gaps;
        logic [1:0]      bresp;
        logic [7:0][7:0] strb;   // expected wstrb, beat n in strb[n]
    } vec_t;

    vec_t vecs [8];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [31:0] addr, input int len, input int size,
                                 input int id, input int aw_delay, input bit gaps,
                                 input int bresp, input logic [63:0] strb);
        vec_t v;
        v.addr     = addr;
        v.len      = 8'(len);
        v.size     = 3'(size);
        v.id       = 4'(id);
        v.aw_delay = 8'(aw_delay);
        v.gaps     = gaps;
        v.bresp    = 2'(bresp);
        v.strb     = strb;
        return v;
    endfunction

    function automatic logic [63:0] beat_data(input int vi, input int b);
        return 64'hA5A5_0000_0000_0000 | (64'(vi) << 16) | 64'(b);
    endfunction

    task automatic reset_checks(input string tag);
        check({tag, "_awvalid"},  64'(bus64.awvalid),   64'd0);
        check({tag, "_wvalid"},   64'(bus64.wvalid),    64'd0);
        check({tag, "_wlast"},    64'(bus64.wlast),     64'd0);
        check({tag, "_bready"},   64'(bus64.bready),    64'd0);
        check({tag, "_rsp_valid"},64'(bus64.rsp_valid), 64'd0);
        check({tag, "_rsp_resp"}, 64'(bus64.rsp_resp),  64'd0);
        check({tag, "_wstrb"},    64'(bus64.wstrb),     64'd0);
        check({tag, "_wdata"},    bus64.wdata,          64'd0);
        check({tag, "_req_ready"},64'(bus64.req_ready), 64'd1);
        check({tag, "_wd_ready"}, 64'(bus64.wd_ready),  64'd0);
    endtask

    // Runs one burst on the 64-bit DUT, acting as CPU and AXI slave.
    task automatic run_burst(input vec_t v, input int vi);
        int cyc = 0;
        int bin = 0;
        int bout = 0;
        bit req_hs = 0, aw_hs = 0, aw_seen = 0, done = 0, stalled = 0;
        logic [63:0] prev_wdata = '0;
        int nbeats = int'(v.len) + 1;
        @(negedge clk);
        bus64.req_id   = v.id;
        bus64.req_addr = v.addr;
        bus64.req_len  = v.len;
        bus64.req_size = v.size;
        while (!done && cyc < 300) begin
            bus64.req_valid = !req_hs;
            bus64.wd_valid  = (bin < nbeats) && (!v.gaps || $urandom_range(0, 2) != 0);
            bus64.wd_data   = beat_data(vi, bin);
            bus64.wready    = !v.gaps || ($urandom_range(0, 2) != 0);
            bus64.awready   = (cyc >= int'(v.aw_delay));
            bus64.bvalid    = aw_hs && (bout == nbeats);
            bus64.bresp     = v.bresp;
            #1;
            if (stalled) begin
                check("wvalid_hold", 64'(bus64.wvalid), 64'd1);
                check("wdata_hold", bus64.wdata, prev_wdata);
            end
            if (bus64.req_valid && bus64.req_ready) req_hs = 1;
            if (aw_hs) check("aw_after_hs", 64'(bus64.awvalid), 64'd0);
            if (bus64.awvalid) begin
                if (!aw_seen) begin
                    check("awid",    64'(bus64.awid),    64'(v.id));
                    check("awlen",   64'(bus64.awlen),   64'(v.len));
                    check("awsize",  64'(bus64.awsize),  64'(v.size));
                    check("awburst", 64'(bus64.awburst), 64'd1);
                    aw_seen = 1;
                end
                check("awaddr", 64'(bus64.awaddr), 64'(v.addr));
                if (bus64.awready) aw_hs = 1;
            end
            if (bus64.wvalid && bus64.wready) begin
                if (bout < nbeats) begin
                    check($sformatf("v%0d_b%0d_wdata", vi, bout), bus64.wdata, beat_data(vi, bout));
                    check($sformatf("v%0d_b%0d_wstrb", vi, bout), 64'(bus64.wstrb),
                          (bout < 8) ? 64'(v.strb[bout]) : 64'hFF);
                    check($sformatf("v%0d_b%0d_wlast", vi, bout), 64'(bus64.wlast),
                          64'(bout == nbeats - 1));
                end else begin
                    check("extra_w_beat", 64'(bout), 64'(nbeats - 1));
                end
                bout++;
            end
            stalled    = bus64.wvalid && !bus64.wready;
            prev_wdata = bus64.wdata;
            if (bus64.wd_valid && bus64.wd_ready) bin++;
            if (bus64.rsp_valid) begin
                check($sformatf("v%0d_rsp_resp", vi), 64'(bus64.rsp_resp), 64'(v.bresp));
                check("rsp_after_aw", 64'(aw_hs), 64'd1);
                check("rsp_w_beats", 64'(bout), 64'(nbeats));
                done = 1;
            end
            cyc++;
            @(negedge clk);
        end
        if (!done) check($sformatf("v%0d_timeout", vi), 64'(done), 64'd1);
        bus64.req_valid = 0;
        bus64.wd_valid  = 0;
        bus64.bvalid    = 0;
        bus64.awready   = 0;
        #1;
        check("rsp_pulse_end", 64'(bus64.rsp_valid), 64'd0);
        check("idle_req_ready", 64'(bus64.req_ready), 64'd1);
        check("idle_wvalid", 64'(bus64.wvalid), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus64.req_valid = 0; bus64.req_id = 0; bus64.req_addr = 0; bus64.req_len = 0;
        bus64.req_size = 0;  bus64.wd_valid = 0; bus64.wd_data = 0; bus64.awready = 0;
        bus64.wready = 0;    bus64.bvalid = 0; bus64.bresp = 0; bus64.bid = 0;
        bus32.req_valid = 0; bus32.req_id = 0; bus32.req_addr = 0; bus32.req_len = 0;
        bus32.req_size = 0;  bus32.wd_valid = 0; bus32.wd_data = 0; bus32.awready = 0;
        bus32.wready = 0;    bus32.bvalid = 0; bus32.bresp = 0; bus32.bid = 0;

        vecs[0] = mkv(32'h8000_0000, 3, 3, 5, 0,  0, 0, 64'h0000_0000_FFFF_FFFF);
        vecs[1] = mkv(32'h0000_1003, 1, 2, 1, 0,  0, 0, 64'h0000_0000_0000_F008);
        vecs[2] = mkv(32'h0000_2000, 3, 3, 2, 10, 0, 0, 64'h0000_0000_FFFF_FFFF);
        vecs[3] = mkv(32'h0000_3000, 7, 3, 3, 0,  1, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        vecs[4] = mkv(32'h0000_4005, 2, 0, 4, 0,  0, 0, 64'h0000_0000_0080_4020);
        vecs[5] = mkv(32'h0000_5002, 3, 1, 6, 2,  0, 0, 64'h0000_0000_03C0_300C);
        vecs[6] = mkv(32'h0000_6006, 1, 3, 7, 0,  1, 3, 64'h0000_0000_0000_FFC0);
        vecs[7] = mkv(32'hFFFF_FFFC, 1, 2, 8, 0,  0, 0, 64'h0000_0000_0000_0FF0);

        repeat (3) @(negedge clk);
        #1;
        reset_checks("reset");
        reset_n = 1;

        for (int i = 0; i < 8; i++) run_burst(vecs[i], i);

        // Oversized request on the 32-bit instance is answered locally
        @(negedge clk);
        bus32.req_valid = 1; bus32.req_addr = 32'h100; bus32.req_len = 2; bus32.req_size = 3;
        #1;
        check("rej_req_ready", 64'(bus32.req_ready), 64'd1);
        @(negedge clk);
        bus32.req_valid = 0;
        #1;
        check("rej_rsp_valid", 64'(bus32.rsp_valid), 64'd1);
        check("rej_rsp_resp",  64'(bus32.rsp_resp),  64'd2);
        check("rej_awvalid",   64'(bus32.awvalid),   64'd0);
        check("rej_wd_ready",  64'(bus32.wd_ready),  64'd0);
        @(negedge clk);
        #1;
        check("rej_rsp_end",   64'(bus32.rsp_valid), 64'd0);
        check("rej_idle",      64'(bus32.req_ready), 64'd1);
        check("rej_no_aw",     64'(bus32.awvalid),   64'd0);

        // Reset in the middle of a len-5 burst while AW is stalled
        @(negedge clk);
        bus64.req_valid = 1; bus64.req_addr = 32'h7000; bus64.req_len = 5; bus64.req_size = 3;
        bus64.req_id = 9; bus64.awready = 0; bus64.wready = 1; bus64.wd_valid = 1;
        bus64.wd_data = 64'hDEAD_BEEF_0000_0001;
        @(negedge clk);
        bus64.req_valid = 0;
        repeat (2) @(negedge clk);
        #1;
        check("mid_wvalid", 64'(bus64.wvalid), 64'd1);
        check("mid_awvalid", 64'(bus64.awvalid), 64'd1);
        reset_n = 0;
        bus64.wd_valid = 0;
        bus64.wready = 0;
        @(negedge clk);
        #1;
        reset_checks("midrst");
        reset_n = 1;

        run_burst(vecs[1], 9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
